// File: rtl/axis_len_checker.sv
// axis_len_checker: checks AXIS packets against the beat count declared in TUSER and forwards them through a 2-entry skid
//   i_clk, i_rst_n                         clock, synchronous active-low reset
//   i_s_axis_*  / o_s_axis_ready           input stream; user = declared length in beats (first beat only)
//   o_m_axis_*  / i_m_axis_ready           forwarded stream; user = latched length, last forced on overrun
//   o_pkt_done, o_pkt_bytes, o_err_*       per-packet status, valid with the done pulse
//   o_pkt_cnt, o_err_cnt                   wrapping packet and errored-packet counters
module axis_len_checker #(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_KEEP_WIDTH = 8,
    parameter int P_USER_WIDTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [P_DATA_WIDTH-1:0] i_s_axis_data,
    input  logic [P_USER_WIDTH-1:0] i_s_axis_user,
    input  logic [P_KEEP_WIDTH-1:0] i_s_axis_keep,
    input  logic                    i_s_axis_last,
    input  logic                    i_s_axis_valid,
    output logic                    o_s_axis_ready,
    output logic [P_DATA_WIDTH-1:0] o_m_axis_data,
    output logic [P_USER_WIDTH-1:0] o_m_axis_user,
    output logic [P_KEEP_WIDTH-1:0] o_m_axis_keep,
    output logic                    o_m_axis_last,
    output logic                    o_m_axis_valid,
    input  logic                    i_m_axis_ready,
    output logic                    o_pkt_done,
    output logic [P_USER_WIDTH+3:0] o_pkt_bytes,
    output logic                    o_err_short,
    output logic                    o_err_long,
    output logic                    o_err_keep,
    output logic [31:0]             o_pkt_cnt,
    output logic [31:0]             o_err_cnt
);
    localparam int BW = P_USER_WIDTH + 4;

    typedef enum logic [1:0] {S_IDLE, S_BODY, S_DRAIN} state_e;

    typedef struct packed {
        logic [P_DATA_WIDTH-1:0] data;
        logic [P_KEEP_WIDTH-1:0] keep;
        logic [P_USER_WIDTH-1:0] user;
        logic                    last;
    } beat_t;

    state_e                  state_q;
    logic [P_USER_WIDTH-1:0] len_q, cnt_q;
    logic                    acc_short_q, acc_long_q, acc_keep_q;
    logic [BW-1:0]           acc_bytes_q;
    beat_t                   out_q, out_d, skid_q, skid_d, in_beat;
    logic                    out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, ready_q;
    logic                    done_q, short_q, long_q, keep_err_q;
    logic [BW-1:0]           bytes_q;
    logic [31:0]             pkt_cnt_q, err_cnt_q;

    logic                    accept, in_idle, len_zero, hit_len, fwd, fin, keep_ok;
    logic                    n_short, n_long, n_keep, end_drain, pkt_end, f_short, f_long, f_keep;
    logic [P_USER_WIDTH-1:0] eff_len, idx, n;
    logic [BW-1:0]           pop, beat_bytes, f_bytes;

    // Per-beat decode: on the first beat everything comes from the input, later beats use the latched length.
    always_comb begin
        accept     = i_s_axis_valid && ready_q;
        in_idle    = state_q == S_IDLE;
        len_zero   = in_idle && i_s_axis_user == '0;
        eff_len    = in_idle ? (len_zero ? P_USER_WIDTH'(1) : i_s_axis_user) : len_q;
        idx        = in_idle ? '0 : cnt_q;
        n          = idx + P_USER_WIDTH'(1);
        hit_len    = n == eff_len;
        fwd        = accept && state_q != S_DRAIN;
        // The forwarded final beat is either the real last or the beat that reaches the declared length.
        fin        = i_s_axis_last || hit_len;
        keep_ok    = fin ? (i_s_axis_keep != '0 && (i_s_axis_keep & (i_s_axis_keep + P_KEEP_WIDTH'(1))) == '0)
                         : &i_s_axis_keep;
        pop        = '0;
        for (int k = 0; k < P_KEEP_WIDTH; k++) pop = pop + BW'(i_s_axis_keep[k]);
        beat_bytes = BW'(idx) * BW'(P_KEEP_WIDTH) + pop;
        // A zero length behaves as one beat and is reported as short, never long.
        n_short    = len_zero || (i_s_axis_last && !hit_len);
        n_long     = hit_len && !i_s_axis_last && !len_zero;
        n_keep     = (!in_idle && acc_keep_q) || !keep_ok;
        end_drain  = accept && state_q == S_DRAIN && i_s_axis_last;
        pkt_end    = end_drain || (fwd && i_s_axis_last);
        f_short    = end_drain ? acc_short_q : n_short;
        f_long     = end_drain ? acc_long_q : n_long;
        f_keep     = end_drain ? acc_keep_q : n_keep;
        f_bytes    = end_drain ? acc_bytes_q : beat_bytes;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_short_q <= 1'b0;
            acc_long_q  <= 1'b0;
            acc_keep_q  <= 1'b0;
            acc_bytes_q <= '0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            keep_err_q  <= 1'b0;
            bytes_q     <= '0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            done_q <= pkt_end;
            if (fwd) begin
                len_q       <= eff_len;
                cnt_q       <= n;
                acc_short_q <= n_short;
                acc_long_q  <= n_long;
                acc_keep_q  <= n_keep;
                acc_bytes_q <= beat_bytes;
                state_q     <= i_s_axis_last ? S_IDLE : hit_len ? S_DRAIN : S_BODY;
            end else if (end_drain) begin
                state_q <= S_IDLE;
            end
            if (pkt_end) begin
                short_q    <= f_short;
                long_q     <= f_long;
                keep_err_q <= f_keep;
                bytes_q    <= f_bytes;
                pkt_cnt_q  <= pkt_cnt_q + 32'd1;
                err_cnt_q  <= err_cnt_q + 32'(f_short || f_long || f_keep);
            end
        end
    end

    // Skid: an enqueue only happens while ready was high, i.e. while the skid register is empty.
    always_comb begin
        in_beat.data = i_s_axis_data;
        in_beat.keep = i_s_axis_keep;
        in_beat.user = eff_len;
        in_beat.last = fin;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || i_m_axis_ready) begin
            out_valid_d  = skid_valid_q || fwd;
            out_d        = skid_valid_q ? skid_q : fwd ? in_beat : out_q;
            skid_valid_d = 1'b0;
        end else if (fwd) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            out_q        <= beat_t'{data: '0, keep: '1, user: '0, last: 1'b0};
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign o_s_axis_ready = ready_q;
    assign o_m_axis_data  = out_q.data;
    assign o_m_axis_user  = out_q.user;
    assign o_m_axis_keep  = out_q.keep;
    assign o_m_axis_last  = out_q.last;
    assign o_m_axis_valid = out_valid_q;
    assign o_pkt_done     = done_q;
    assign o_pkt_bytes    = bytes_q;
    assign o_err_short    = short_q;
    assign o_err_long     = long_q;
    assign o_err_keep     = keep_err_q;
    assign o_pkt_cnt      = pkt_cnt_q;
    assign o_err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_axis_len_checker.sv
// tb_axis_len_checker: randomized packets checked against a packet-level reference model
module tb_axis_len_checker;
    logic        i_clk = 1'b0, i_rst_n = 1'b0;
    logic [63:0] i_s_axis_data = '0;
    logic [15:0] i_s_axis_user = '0;
    logic [7:0]  i_s_axis_keep = '0;
    logic        i_s_axis_last = 1'b0, i_s_axis_valid = 1'b0, i_m_axis_ready = 1'b0;
    logic        o_s_axis_ready, o_m_axis_last, o_m_axis_valid, o_pkt_done, o_err_short, o_err_long, o_err_keep;
    logic [63:0] o_m_axis_data;
    logic [15:0] o_m_axis_user;
    logic [7:0]  o_m_axis_keep;
    logic [19:0] o_pkt_bytes;
    logic [31:0] o_pkt_cnt, o_err_cnt;

    axis_len_checker dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_s_axis_data(i_s_axis_data), .i_s_axis_user(i_s_axis_user), .i_s_axis_keep(i_s_axis_keep),
        .i_s_axis_last(i_s_axis_last), .i_s_axis_valid(i_s_axis_valid), .o_s_axis_ready(o_s_axis_ready),
        .o_m_axis_data(o_m_axis_data), .o_m_axis_user(o_m_axis_user), .o_m_axis_keep(o_m_axis_keep),
        .o_m_axis_last(o_m_axis_last), .o_m_axis_valid(o_m_axis_valid), .i_m_axis_ready(i_m_axis_ready),
        .o_pkt_done(o_pkt_done), .o_pkt_bytes(o_pkt_bytes), .o_err_short(o_err_short),
        .o_err_long(o_err_long), .o_err_keep(o_err_keep), .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [63:0] data; logic [7:0] keep; logic [15:0] user; logic last, fwd, fin; } in_t;
    typedef struct { logic [63:0] data; logic [7:0] keep; logic [15:0] user; logic last; } out_t;
    typedef struct { logic [19:0] bytes; logic s, l, k; } st_t;

    in_t        in_q[$];
    out_t       out_q[$];
    st_t        st_q[$];
    logic [7:0] kq[$];
    int         checks = 0, failures = 0;
    int         exp_pkts = 0, exp_errs = 0, occ = 0, m_duty = 100, gap = 0;
    logic       exp_done = 1'b0, mon_en = 1'b0, cur_fwd = 1'b0, cur_fin = 1'b0;
    st_t        mon_s;
    out_t       mon_o;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int popc(input logic [7:0] k);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(k[i]);
        return c;
    endfunction

    // Packet-level model: forwarded beats = min(beats, max(user,1)), flags from the length and keep rules.
    task automatic add_pkt(input int u);
        int   k = kq.size();
        int   len = (u == 0) ? 1 : u;
        int   f = (k < len) ? k : len;
        logic kerr = 1'b0;
        st_t  st;
        for (int i = 0; i < k; i++) begin
            in_t  b;
            out_t o;
            b.data = {$urandom, $urandom};
            b.keep = kq[i];
            b.user = (i == 0) ? 16'(u) : 16'($urandom);
            b.last = (i == k - 1);
            b.fwd  = (i < f);
            b.fin  = (i == k - 1);
            in_q.push_back(b);
            if (i < f) begin
                o.data = b.data;
                o.keep = b.keep;
                o.user = 16'(len);
                o.last = (i == f - 1);
                out_q.push_back(o);
                if (i == f - 1) kerr |= (kq[i] == 8'h00) || ((kq[i] & (kq[i] + 8'h01)) != 8'h00);
                else kerr |= (kq[i] != 8'hFF);
            end
        end
        st.bytes = 20'((f - 1) * 8 + popc(kq[f - 1]));
        st.s     = (u == 0) || (k < len);
        st.l     = (u != 0) && (k > len);
        st.k     = kerr;
        st_q.push_back(st);
    endtask

    task automatic send(input int n);
        for (int j = 0; j < n && in_q.size() > 0; j++) begin
            in_t  b = in_q.pop_front();
            int   t = 0;
            logic acc = 1'b0;
            while ($urandom_range(0, 99) < gap) begin
                @(posedge i_clk);
                #1;
            end
            i_s_axis_data  = b.data;
            i_s_axis_keep  = b.keep;
            i_s_axis_user  = b.user;
            i_s_axis_last  = b.last;
            cur_fwd        = b.fwd;
            cur_fin        = b.fin;
            i_s_axis_valid = 1'b1;
            do begin
                @(negedge i_clk);
                acc = o_s_axis_ready;
                @(posedge i_clk);
                #1;
                t++;
            end while (!acc && t < 500);
            if (!acc) check("accept_timeout", 0, 1);
            i_s_axis_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((out_q.size() > 0 || st_q.size() > 0) && t < 3000) begin
            @(posedge i_clk);
            t++;
        end
        check("drain_timeout", 64'(out_q.size() + st_q.size()), 0);
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en         = 1'b0;
        i_s_axis_valid = 1'b0;
        i_rst_n        = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        in_q.delete();
        out_q.delete();
        st_q.delete();
        occ      = 0;
        exp_done = 1'b0;
        exp_pkts = 0;
        exp_errs = 0;
        check("rst_s_ready", o_s_axis_ready, 0);
        check("rst_m_valid", o_m_axis_valid, 0);
        check("rst_m_data", o_m_axis_data, 0);
        check("rst_m_keep", o_m_axis_keep, 8'hFF);
        check("rst_m_user", o_m_axis_user, 0);
        check("rst_m_last", o_m_axis_last, 0);
        check("rst_done", o_pkt_done, 0);
        check("rst_bytes", o_pkt_bytes, 0);
        check("rst_flags", {o_err_short, o_err_long, o_err_keep}, 0);
        check("rst_pkt_cnt", o_pkt_cnt, 0);
        check("rst_err_cnt", o_err_cnt, 0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        mon_en = 1'b1;
    endtask

    initial forever begin
        @(posedge i_clk);
        #1;
        i_m_axis_ready = ($urandom_range(0, 99) < m_duty);
    end

    // Occupancy of the 2-entry skid follows from beats enqueued minus beats delivered.
    always @(negedge i_clk) if (mon_en) begin
        check("done", o_pkt_done, exp_done);
        exp_done = 1'b0;
        if (o_pkt_done) begin
            if (st_q.size() == 0) check("status_extra", 1, 0);
            else begin
                mon_s = st_q.pop_front();
                exp_pkts++;
                if (mon_s.s || mon_s.l || mon_s.k) exp_errs++;
                check("bytes", o_pkt_bytes, mon_s.bytes);
                check("err_short", o_err_short, mon_s.s);
                check("err_long", o_err_long, mon_s.l);
                check("err_keep", o_err_keep, mon_s.k);
                check("pkt_cnt", o_pkt_cnt, exp_pkts);
                check("err_cnt", o_err_cnt, exp_errs);
            end
        end
        check("s_ready", o_s_axis_ready, occ < 2);
        check("m_valid", o_m_axis_valid, occ > 0);
        if (o_m_axis_valid) begin
            if (out_q.size() == 0) check("beat_extra", 1, 0);
            else begin
                mon_o = out_q[0];
                check("m_data", o_m_axis_data, mon_o.data);
                check("m_keep", o_m_axis_keep, mon_o.keep);
                check("m_user", o_m_axis_user, mon_o.user);
                check("m_last", o_m_axis_last, mon_o.last);
                if (i_m_axis_ready) begin
                    void'(out_q.pop_front());
                    occ--;
                end
            end
        end
        if (i_s_axis_valid && o_s_axis_ready) begin
            if (cur_fwd) occ++;
            if (cur_fin) exp_done = 1'b1;
        end
    end

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        m_duty = 100;
        gap    = 0;
        kq = '{8'hFF, 8'hFF, 8'hFF, 8'h0F}; add_pkt(4);
        kq = '{8'hFF, 8'hFF, 8'h0F};        add_pkt(5);
        kq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; add_pkt(2);
        kq = '{8'h05};                      add_pkt(1);
        kq = '{8'h7F, 8'hFF, 8'hFF};        add_pkt(3);
        kq = '{8'h0F};                      add_pkt(0);
        kq = '{8'hFF, 8'hFF, 8'hFF};        add_pkt(0);
        send(in_q.size());
        wait_idle();
        check("dir_pkt_cnt", o_pkt_cnt, 7);
        check("dir_err_cnt", o_err_cnt, 6);

        do_reset();
        m_duty = 30;
        gap    = 20;
        for (int p = 0; p < 100; p++) begin
            int k = $urandom_range(1, 8);
            kq.delete();
            for (int i = 0; i < k - 1; i++)
                kq.push_back(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF);
            kq.push_back(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'((1 << $urandom_range(1, 8)) - 1));
            add_pkt($urandom_range(0, 6));
        end
        send(in_q.size());
        wait_idle();
        check("rand_pkt_cnt", o_pkt_cnt, 100);

        m_duty = 100;
        gap    = 0;
        kq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; add_pkt(4);
        send(2);
        do_reset();
        kq = '{8'hFF, 8'hFF, 8'hFF, 8'h0F}; add_pkt(4);
        send(in_q.size());
        wait_idle();
        check("post_rst_pkt_cnt", o_pkt_cnt, 1);
        check("post_rst_err_cnt", o_err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
